// File: rtl/memory_pkg.sv
// Shared definitions for the banked, self-clearing RAM.
package memory_pkg;

  // Controller states: zeroing the array, or serving loads/reads.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Width of the bank-select slice taken from the top of the address.
  // Clamped so at least one index bit always remains.
  function automatic int unsigned bank_sel_width(input int unsigned addr_w,
                                                 input int unsigned bank_bits);
    if (bank_bits == 0) return 1;
    if (bank_bits >= addr_w) return addr_w - 1;
    return bank_bits;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// One memory bank: synchronous write port, combinational read port.
module ram_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**IDX_W];

  // Write port; contents are never reset, the clear engine zeros them.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/ram_banked_clr.sv
// Banked word memory with a registered read port and a hardware clear engine.
// Top address bits pick the bank, low bits index within it.
module ram_banked_clr #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BANK_BITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  output logic [DATA_W-1:0] out,
  output logic              ready
);
  import memory_pkg::*;

  localparam int unsigned BSEL_W = bank_sel_width(ADDR_W, BANK_BITS);
  localparam int unsigned IDX_W  = ADDR_W - BSEL_W;
  localparam int unsigned NBANK  = 1 << BSEL_W;

  state_e            state_q;
  logic [IDX_W-1:0]  clr_cnt_q;
  logic [DATA_W-1:0] out_q;
  logic              ready_q;

  logic [BSEL_W-1:0] bank_sel;
  logic [IDX_W-1:0]  idx;
  logic              clr_active;
  logic              user_wr;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data [NBANK];
  logic [DATA_W-1:0] rd_word;

  assign bank_sel   = adr[ADDR_W-1 -: BSEL_W];
  assign idx        = adr[IDX_W-1:0];
  assign clr_active = (state_q == ST_CLEAR);
  // A clear request wins over a simultaneous load.
  assign user_wr    = (state_q == ST_READY) && load && !clear;
  assign rd_word    = rd_data[bank_sel];

  // Write-port mux: the clear engine drives zeros at clr_cnt, otherwise user data at idx.
  always_comb begin
    wr_idx  = idx;
    wr_data = data;
    if (clr_active) begin
      wr_idx  = clr_cnt_q;
      wr_data = '0;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    logic bank_we;
    // Clearing hits every bank at once; user writes only the selected one.
    assign bank_we = clr_active || (user_wr && (bank_sel == BSEL_W'(b)));

    ram_bank #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
    ) u_bank (
      .clk_i     (clk),
      .we_i      (bank_we),
      .wr_idx_i  (wr_idx),
      .wr_data_i (wr_data),
      .rd_idx_i  (idx),
      .rd_data_o (rd_data[b])
    );
  end

  // Controller FSM with registered out/ready; read data is write-first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      out_q     <= '0;
      ready_q   <= 1'b0;
    end else if (clear) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      out_q     <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          out_q     <= '0;
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (&clr_cnt_q) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end
        end
        ST_READY: begin
          out_q <= load ? data : rd_word;
        end
        default: begin
          state_q <= ST_CLEAR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign out   = out_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_ram_banked_clr.sv
// Scoreboard bench for ram_banked_clr: the driver pushes model predictions,
// a monitor pops and compares after each rising edge.
module tb_ram_banked_clr;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int BB    = 3;
  localparam int DEPTH = 1 << (AW - BB);
  localparam int S_AW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic [AW-1:0] adr = '0;
  logic [DW-1:0] data = '0;
  logic          load = 1'b0;
  logic [DW-1:0] out;
  logic          ready;

  logic            s_reset = 1'b1;
  logic            s_clear = 1'b0;
  logic [S_AW-1:0] s_adr = '0;
  logic [DW-1:0]   s_data = '0;
  logic            s_load = 1'b0;
  logic [DW-1:0]   s_out;
  logic            s_ready;

  always #5 clk = ~clk;

  ram_banked_clr #(.DATA_W(DW), .ADDR_W(AW), .BANK_BITS(BB)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .adr   (adr),
    .data  (data),
    .load  (load),
    .out   (out),
    .ready (ready)
  );

  ram_banked_clr #(.DATA_W(DW), .ADDR_W(S_AW), .BANK_BITS(2)) dut_s (
    .clk   (clk),
    .reset (s_reset),
    .clear (s_clear),
    .adr   (s_adr),
    .data  (s_data),
    .load  (s_load),
    .out   (s_out),
    .ready (s_ready)
  );

  typedef struct packed {
    logic [DW-1:0] out;
    logic          ready;
  } exp_t;

  exp_t          sb_q[$];
  int            vectors = 0;
  int            errs = 0;

  // Reference model: flat word array plus "edges left until ready".
  logic [DW-1:0] mdl_mem [1 << AW];
  int            clr_left;

  function automatic void mdl_wipe();
    for (int i = 0; i < (1 << AW); i++) mdl_mem[i] = '0;
    clr_left = DEPTH;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs (caller is at a falling edge) and predict the next edge.
  task automatic step(input logic ld, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic clr);
    exp_t e;
    load  = ld;
    adr   = a;
    data  = d;
    clear = clr;
    if (clr) begin
      mdl_wipe();
      e.out   = '0;
      e.ready = 1'b0;
    end else if (clr_left > 0) begin
      clr_left--;
      e.out   = '0;
      e.ready = (clr_left == 0);
    end else begin
      e.ready = 1'b1;
      if (ld) begin
        mdl_mem[a] = d;
        e.out      = d;
      end else begin
        e.out = mdl_mem[a];
      end
    end
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle_clear(input int n);
    for (int i = 0; i < n; i++) step(1'b1, AW'($urandom), DW'($urandom), 1'b0);
  endtask

  // Monitor: compare each edge's outputs against the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      if (out !== e.out || ready !== e.ready) begin
        errs++;
        $display("FAIL vec %0d: out=%h ready=%b expected out=%h ready=%b",
                 vectors, out, ready, e.out, e.ready);
      end
    end
  end

  logic [AW-1:0] hot [16];

  initial begin
    int cnt;
    mdl_wipe();
    #2;
    check("reset out", out, '0);
    check("reset ready", {15'd0, ready}, 16'd1 - 16'd1);

    // Release reset; hold load high through the whole clear.
    @(negedge clk);
    reset = 1'b0;
    idle_clear(DEPTH + 2);

    // Directed writes and reads at bank 0 and bank 7.
    step(1'b1, 12'h000, 16'hBEEF, 1'b0);
    step(1'b1, 12'hE00, 16'h1234, 1'b0);
    step(1'b0, 12'h000, 16'h0, 1'b0);
    step(1'b0, 12'hE00, 16'h0, 1'b0);

    // Bank isolation at index 5.
    step(1'b1, 12'h005, 16'hAAAA, 1'b0);
    for (int b = 0; b < 8; b++) step(1'b0, {3'(b), 9'h005}, 16'h0, 1'b0);

    // Clear with a concurrent load; the load must be lost.
    step(1'b1, 12'h001, 16'h5555, 1'b1);
    idle_clear(DEPTH);
    step(1'b0, 12'h000, 16'h0, 1'b0);
    step(1'b0, 12'hE00, 16'h0, 1'b0);
    step(1'b0, 12'h001, 16'h0, 1'b0);

    // Re-pulse clear 100 cycles into a clear.
    step(1'b0, 12'h000, 16'h0, 1'b1);
    idle_clear(99);
    step(1'b0, 12'h000, 16'h0, 1'b1);
    idle_clear(DEPTH + 1);

    // Randomized traffic, biased onto a small hot address set.
    for (int i = 0; i < 16; i++) hot[i] = AW'($urandom);
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(1, 0) == 1) ? hot[$urandom_range(15, 0)] : AW'($urandom);
      step(1'($urandom), a, DW'($urandom), $urandom_range(399, 0) == 0);
    end
    idle_clear(DEPTH);

    // Asynchronous reset between edges, just after a write.
    step(1'b1, 12'h123, 16'hC0DE, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async reset out", out, '0);
    check("async reset ready", {15'd0, ready}, '0);
    mdl_wipe();
    @(negedge clk);
    reset = 1'b0;
    idle_clear(DEPTH);
    step(1'b0, 12'h123, 16'h0, 1'b0);
    step(1'b0, 12'h000, 16'h0, 1'b0);

    // Small instance: clear must last 64 edges.
    s_reset = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (s_ready) begin
        cnt = i;
        break;
      end
    end
    check("small clear edges", DW'(cnt), DW'(64));
    @(negedge clk);
    s_load = 1'b1;
    s_adr  = 8'hC3;
    s_data = 16'h77AA;
    @(posedge clk);
    #1;
    check("small write-first", s_out, 16'h77AA);
    @(negedge clk);
    s_load = 1'b0;
    @(posedge clk);
    #1;
    check("small readback", s_out, 16'h77AA);
    @(negedge clk);
    s_adr = 8'h03;
    @(posedge clk);
    #1;
    check("small other bank", s_out, '0);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard drained", DW'(sb_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
